dual_divider_top: RTL and testbench

- Unsigned 8-bit integer divider block computing x / y with two independent algorithms in parallel.
- Quotient/remainder pair z1/r1 comes from a restoring-division datapath; pair z2/r2 comes from a non-restoring (add/subtract-alternating) datapath.
- Top level of the division experiment; a single start pulse launches both cores and a shared busy flag reports progress.
- Both pairs must always agree; this cross-check is the main verification hook.

---
 rtl/dual_divider_top.sv | 120 ++++++++++++
 tb/tb_dual_divider_top.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dual_divider_top.sv
`timescale 1ns/1ps
// rtl/dual_divider_top.sv - unsigned divider with parallel restoring and non-restoring cores
module dual_divider_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             start,
    output logic [WIDTH-1:0] z1,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] z2,
    output logic [WIDTH-1:0] r2,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] rem1;
    logic [WIDTH:0]   rem2;

    logic [WIDTH:0]   sh1;
    logic             ge1;
    logic [WIDTH-1:0] diff1;
    logic [WIDTH-1:0] rem1_nxt;
    logic [WIDTH+1:0] sh2;
    logic [WIDTH+1:0] add2;
    logic [WIDTH-1:0] rem2_fix;

    // Restoring step: remainder always stays below the divisor, so WIDTH bits hold it
    always_comb begin
        sh1      = {rem1, dvd[WIDTH-1]};
        ge1      = (sh1 >= {1'b0, dvs});
        diff1    = sh1[WIDTH-1:0] - dvs;
        rem1_nxt = ge1 ? diff1 : sh1[WIDTH-1:0];
    end

    // Non-restoring step: stored remainder lies in [-dvs, dvs-1]; one guard bit covers 2*rem+bit
    always_comb begin
        sh2      = {rem2, dvd[WIDTH-1]};
        add2     = rem2[WIDTH] ? (sh2 + {2'b00, dvs}) : (sh2 - {2'b00, dvs});
        rem2_fix = rem2[WIDTH-1:0] + (rem2[WIDTH] ? dvs : {WIDTH{1'b0}});
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt  <= '0;
            dvd  <= '0;
            dvs  <= '0;
            q1   <= '0;
            q2   <= '0;
            rem1 <= '0;
            rem2 <= '0;
            z1   <= '0;
            r1   <= '0;
            z2   <= '0;
            r2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd  <= x;
                        dvs  <= y;
                        q1   <= '0;
                        q2   <= '0;
                        rem1 <= '0;
                        rem2 <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    dvd  <= {dvd[WIDTH-2:0], 1'b0};
                    rem1 <= rem1_nxt;
                    q1   <= {q1[WIDTH-2:0], ge1};
                    rem2 <= add2[WIDTH:0];
                    q2   <= {q2[WIDTH-2:0], ~add2[WIDTH+1]};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    z1 <= q1;
                    r1 <= rem1;
                    z2 <= q2;
                    r2 <= rem2_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_divider_top.sv
`timescale 1ns/1ps
// tb/tb_dual_divider_top.sv - scoreboard bench for dual_divider_top against an arithmetic reference
module tb_dual_divider_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] x = 8'd0;
    logic [7:0] y = 8'd0;
    logic [7:0] z1, r1, z2, r2;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;
    bit abort_run = 1'b0;

    typedef struct {
        int z;
        int r;
    } exp_t;

    exp_t exp_q[$];

    dual_divider_top #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .start (start),
        .z1    (z1),
        .r1    (r1),
        .z2    (z2),
        .r2    (r2),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.z = 255;
            e.r = a;
        end else begin
            e.z = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: a falling busy marks a completed division
    initial begin
        int  busy_len = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (abort_run || rst_n) begin
                busy_len = 0;
            end else if (busy) begin
                busy_len++;
            end else if (prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("z1", int'(z1), e.z);
                    check("r1", int'(r1), e.r);
                    check("z2", int'(z2), e.z);
                    check("r2", int'(r2), e.r);
                    check("busy_cycles", busy_len, 9);
                end
                busy_len = 0;
            end
            prev = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int a, input int b, input bit expect_result);
        wait_idle();
        x = 8'(a);
        y = 8'(b);
        start = 1'b1;
        if (expect_result) exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int a, input int b);
        issue(a, b, 1'b1);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_z1", int'(z1), 0);
        check("rst_r1", int'(r1), 0);
        check("rst_z2", int'(z2), 0);
        check("rst_r2", int'(r2), 0);
        rst_n = 1'b0;
        @(negedge clk);

        run(81, 7);
        run(200, 13);
        run(255, 1);
        run(5, 9);
        run(100, 0);
        run(0, 255);
        run(255, 255);
        run(254, 255);

        // start and operand changes while busy must be ignored
        issue(81, 7, 1'b1);
        x = 8'd10;
        y = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'd55;
        y = 8'd2;
        wait_idle();
        repeat (2) @(negedge clk);
        check("no_extra_start", int'(busy), 0);

        // reset mid-run aborts without writing a result
        issue(200, 13, 1'b0);
        repeat (3) @(negedge clk);
        abort_run = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_z1", int'(z1), 0);
        check("abort_r1", int'(r1), 0);
        check("abort_z2", int'(z2), 0);
        check("abort_r2", int'(r2), 0);
        rst_n = 1'b0;
        @(negedge clk);
        abort_run = 1'b0;
        run(81, 7);

        // start held high: second operation accepted right after the first completes
        wait_idle();
        x = 8'd50;
        y = 8'd6;
        start = 1'b1;
        exp_q.push_back(model(50, 6));
        @(negedge clk);
        x = 8'd77;
        y = 8'd0;
        exp_q.push_back(model(77, 0));
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_idle_seen", int'(busy), 0);
        @(negedge clk);
        check("b2b_busy", int'(busy), 1);
        start = 1'b0;
        wait_idle();

        repeat (300) run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
